// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional build macro used by the arbiter: MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

   // Byte-enable width for the default 32-bit data path (DW = 8 * BE_W)
   localparam int unsigned BE_W = 4;

   typedef enum logic {
      IDLE      = 1'b0,
      ACC_BURST = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_ACC = 1'b1
   } owner_t;

   // Who owned the port last cycle, and whether that access was a read
   typedef struct packed {
      logic   rd;
      owner_t owner;
   } rd_owner_t;

   function automatic logic is_read_of(input rd_owner_t ro, input owner_t who);
      return ro.rd && (ro.owner == who);
   endfunction

endpackage

// File: rtl/mem_arb_rdata_hold.sv
// Keeps CPU load data stable while the pipeline is frozen: load data that
// returns during a stall is captured and replayed until the stall lifts.
module mem_arb_rdata_hold #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          capture,
   input  logic          cpu_stall,
   input  logic [DW-1:0] mem_read_data,
   output logic [DW-1:0] cpu_mem_read_data
);

   logic          hold_valid;
   logic [DW-1:0] hold_q;

   // Hold-valid flag: set on capture, cleared on the first unstalled cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
      end else if (en) begin
         if (capture) begin
            hold_valid <= 1'b1;
         end else if (!cpu_stall) begin
            hold_valid <= 1'b0;
         end
      end
   end

   // Hold data register; only meaningful while hold_valid is set
   always_ff @(posedge clk) begin
      if (en && capture) begin
         hold_q <= mem_read_data;
      end
   end

   // Replay held data while valid, otherwise pass memory straight through
   always_comb begin
      cpu_mem_read_data = hold_valid ? hold_q : mem_read_data;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the CPU M-stage port and one
// accelerator/DMA master. CPU has priority in IDLE; a locked accelerator
// grant keeps ownership (ACC_BURST) until the lock or request drops.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN (forces the accelerator
// through after MAX_WAIT consecutive lost conflicts).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            cpu_mem_read_en,
   input  logic [BE_W-1:0] cpu_mem_write_en,
   input  logic [AW-1:0]   cpu_mem_addr,
   input  logic [DW-1:0]   cpu_mem_write_data,
   output logic [DW-1:0]   cpu_mem_read_data,
   output logic            cpu_stall,
   input  logic            acc_req,
   input  logic            acc_lock,
   input  logic [BE_W-1:0] acc_we,
   input  logic [AW-1:0]   acc_addr,
   input  logic [DW-1:0]   acc_wdata,
   output logic            acc_gnt,
   output logic            acc_rvalid,
   output logic [DW-1:0]   acc_rdata,
   output logic            mem_read_en,
   output logic [BE_W-1:0] mem_write_en,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_write_data,
   input  logic [DW-1:0]   mem_read_data
);

   arb_state_t state, state_nxt;
   rd_owner_t  rd_owner_q, rd_owner_d;
   logic       cpu_act;
   logic       cpu_win;
   logic       acc_win;
   logic       force_acc;
   logic       hold_capture;

   assign cpu_act = cpu_mem_read_en | (|cpu_mem_write_en);

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(MAX_WAIT + 2);
   logic [CW-1:0] wait_cnt;

   // Count consecutive IDLE conflicts the accelerator loses; saturates
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (en) begin
         if (acc_win) begin
            wait_cnt <= '0;
         end else if ((state == IDLE) && acc_req && cpu_act &&
                      (wait_cnt != CW'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   assign force_acc = (wait_cnt == CW'(MAX_WAIT));
`else
   assign force_acc = 1'b0;
`endif

   // State and read-owner registers; everything freezes while en is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rd_owner_q <= '0;
      end else if (en) begin
         state      <= state_nxt;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Arbitration and next state; the burst exit cycle is arbitrated as IDLE
   always_comb begin
      cpu_win   = 1'b0;
      acc_win   = 1'b0;
      state_nxt = state;
      if (en) begin
         if ((state == ACC_BURST) && acc_req && acc_lock) begin
            acc_win = 1'b1;
         end else begin
            state_nxt = IDLE;
            if (cpu_act && !(force_acc && acc_req)) begin
               cpu_win = 1'b1;
            end else if (acc_req) begin
               acc_win = 1'b1;
               if (acc_lock) begin
                  state_nxt = ACC_BURST;
               end
            end
         end
      end
   end

   // Memory-side mux of the winner's payload and the read-owner record
   always_comb begin
      mem_read_en       = 1'b0;
      mem_write_en      = '0;
      mem_addr          = cpu_mem_addr;
      mem_write_data    = cpu_mem_write_data;
      rd_owner_d.rd     = 1'b0;
      rd_owner_d.owner  = OWN_CPU;
      if (cpu_win) begin
         mem_read_en   = cpu_mem_read_en;
         mem_write_en  = cpu_mem_write_en;
         rd_owner_d.rd = cpu_mem_read_en;
      end else if (acc_win) begin
         mem_read_en      = ~(|acc_we);
         mem_write_en     = acc_we;
         mem_addr         = acc_addr;
         mem_write_data   = acc_wdata;
         rd_owner_d.rd    = ~(|acc_we);
         rd_owner_d.owner = OWN_ACC;
      end
   end

   // Master-facing handshakes and returned read data
   always_comb begin
      acc_gnt      = acc_win;
      cpu_stall    = en & cpu_act & ~cpu_win;
      acc_rvalid   = is_read_of(rd_owner_q, OWN_ACC);
      acc_rdata    = mem_read_data;
      hold_capture = is_read_of(rd_owner_q, OWN_CPU) & cpu_stall;
   end

   mem_arb_rdata_hold #(
      .DW (DW)
   ) u_rdata_hold (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .capture           (hold_capture),
      .cpu_stall         (cpu_stall),
      .mem_read_data     (mem_read_data),
      .cpu_mem_read_data (cpu_mem_read_data)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each cycle's hand-computed response
// is queued by the stimulus; a negedge monitor pops and compares. Accelerator
// read data is queued separately and popped whenever acc_rvalid is seen.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst, en;
   logic        cpu_mem_read_en;
   logic [3:0]  cpu_mem_write_en;
   logic [31:0] cpu_mem_addr, cpu_mem_write_data, cpu_mem_read_data;
   logic        cpu_stall;
   logic        acc_req, acc_lock;
   logic [3:0]  acc_we;
   logic [31:0] acc_addr, acc_wdata, acc_rdata;
   logic        acc_gnt, acc_rvalid;
   logic        mem_read_en;
   logic [3:0]  mem_write_en;
   logic [31:0] mem_addr, mem_write_data, mem_read_data;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .en(en),
      .cpu_mem_read_en(cpu_mem_read_en), .cpu_mem_write_en(cpu_mem_write_en),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
      .cpu_mem_read_data(cpu_mem_read_data), .cpu_stall(cpu_stall),
      .acc_req(acc_req), .acc_lock(acc_lock), .acc_we(acc_we),
      .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_gnt(acc_gnt),
      .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   typedef struct {
      logic        gnt, stall, mre;
      logic [3:0]  mwe;
      logic [31:0] addr, wd;
      logic        rv, chk_crd;
      logic [31:0] crd;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] acc_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("acc_gnt", {31'd0, acc_gnt}, {31'd0, e.gnt});
         chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
         chk("mem_read_en", {31'd0, mem_read_en}, {31'd0, e.mre});
         chk("mem_write_en", {28'd0, mem_write_en}, {28'd0, e.mwe});
         chk("acc_rvalid", {31'd0, acc_rvalid}, {31'd0, e.rv});
         if (e.mre || (|e.mwe)) chk("mem_addr", mem_addr, e.addr);
         if (|e.mwe) chk("mem_write_data", mem_write_data, e.wd);
         if (e.chk_crd) chk("cpu_mem_read_data", cpu_mem_read_data, e.crd);
      end
      if (acc_rvalid === 1'b1) begin
         if (acc_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL acc_rvalid_extra: got rvalid=1 required no response (t=%0t)", $time);
         end else begin
            chk("acc_rdata", acc_rdata, acc_q.pop_front());
         end
      end
   end

   task automatic cpu(input logic rd, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
      cpu_mem_read_en = rd; cpu_mem_write_en = we; cpu_mem_addr = a; cpu_mem_write_data = wd;
   endtask

   task automatic acc(input logic req, input logic lock, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
      acc_req = req; acc_lock = lock; acc_we = we; acc_addr = a; acc_wdata = wd;
   endtask

   // Queue this cycle's expected response, then advance one clock
   task automatic step(input logic g, input logic s, input logic mre, input logic [3:0] mwe,
                       input logic [31:0] a, input logic [31:0] wd, input logic rv,
                       input logic cc, input logic [31:0] crd);
      exp_t e;
      e.gnt = g; e.stall = s; e.mre = mre; e.mwe = mwe; e.addr = a; e.wd = wd;
      e.rv = rv; e.chk_crd = cc; e.crd = crd;
      exp_q.push_back(e);
      if (rv) acc_q.push_back(mem_read_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; mem_read_data = '0;
      cpu(0, 4'h0, 32'h0, 32'h0);
      acc(0, 0, 4'h0, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      // reset state
      step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);

      // CPU load alone, data one cycle later
      cpu(1, 4'h0, 32'h100, 0);
      step(0, 0, 1, 4'h0, 32'h100, 0, 0, 0, 0);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'hDEADBEEF;
      step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hDEADBEEF);

      // CPU write beats accelerator read, which goes next cycle
      cpu(0, 4'hF, 32'h300, 32'hC0DE0300); acc(1, 0, 4'h0, 32'h200, 0); mem_read_data = 0;
      step(0, 0, 0, 4'hF, 32'h300, 32'hC0DE0300, 0, 0, 0);
      cpu(0, 4'h0, 0, 0);
      step(1, 0, 1, 4'h0, 32'h200, 0, 0, 0, 0);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'hA0A00200;
      step(0, 0, 0, 4'h0, 0, 0, 1, 0, 0);

      // Locked burst stalls a CPU load for three cycles
      acc(1, 1, 4'h0, 32'h400, 0); mem_read_data = 0;
      step(1, 0, 1, 4'h0, 32'h400, 0, 0, 0, 0);
      cpu(1, 4'h0, 32'h500, 0); acc(1, 1, 4'h0, 32'h404, 0); mem_read_data = 32'h4000;
      step(1, 1, 1, 4'h0, 32'h404, 0, 1, 0, 0);
      acc(1, 1, 4'h0, 32'h408, 0); mem_read_data = 32'h4004;
      step(1, 1, 1, 4'h0, 32'h408, 0, 1, 0, 0);
      acc(1, 1, 4'h0, 32'h40C, 0); mem_read_data = 32'h4008;
      step(1, 1, 1, 4'h0, 32'h40C, 0, 1, 0, 0);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'h400C;
      step(0, 0, 1, 4'h0, 32'h500, 0, 1, 0, 0);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'h5555;
      step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h5555);

      // Burst exit with request still up (unlocked) is a normal IDLE grant
      acc(1, 1, 4'h0, 32'h600, 0); mem_read_data = 0;
      step(1, 0, 1, 4'h0, 32'h600, 0, 0, 0, 0);
      acc(1, 0, 4'h0, 32'h604, 0); mem_read_data = 32'h6000;
      step(1, 0, 1, 4'h0, 32'h604, 0, 1, 0, 0);
      cpu(1, 4'h0, 32'h700, 0); acc(1, 1, 4'h0, 32'h608, 0); mem_read_data = 32'h6004;
      step(0, 0, 1, 4'h0, 32'h700, 0, 1, 0, 0);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'h7000;
      step(1, 0, 1, 4'h0, 32'h608, 0, 0, 1, 32'h7000);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'h6008;
      step(0, 0, 0, 4'h0, 0, 0, 1, 0, 0);

      // Reset mid-burst drops the in-flight read
      acc(1, 1, 4'h0, 32'h800, 0); mem_read_data = 0;
      step(1, 0, 1, 4'h0, 32'h800, 0, 0, 0, 0);
      acc(1, 1, 4'h3, 32'h804, 32'hAAAA5555); mem_read_data = 32'h8000;
      step(1, 0, 0, 4'h3, 32'h804, 32'hAAAA5555, 1, 0, 0);
      rst = 1'b1; acc(1, 1, 4'h0, 32'h808, 0); mem_read_data = 0;
      step(1, 0, 1, 4'h0, 32'h808, 0, 0, 0, 0);
      rst = 1'b0; cpu(1, 4'h0, 32'h900, 0); acc(1, 1, 4'h0, 32'h80C, 0); mem_read_data = 32'h8080;
      step(0, 0, 1, 4'h0, 32'h900, 0, 0, 0, 0);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'h9999;
      step(1, 0, 1, 4'h0, 32'h80C, 0, 0, 1, 32'h9999);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'h80C0;
      step(0, 0, 0, 4'h0, 0, 0, 1, 0, 0);

      // en low: nothing reaches memory and the burst state is kept
      acc(1, 1, 4'hF, 32'hA00, 32'h0A0A0A0A); mem_read_data = 0;
      step(1, 0, 0, 4'hF, 32'hA00, 32'h0A0A0A0A, 0, 0, 0);
      en = 1'b0; cpu(1, 4'h0, 32'hB00, 0); acc(1, 1, 4'h0, 32'hA04, 0);
      step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      en = 1'b1;
      step(1, 1, 1, 4'h0, 32'hA04, 0, 0, 0, 0);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'hA040;
      step(0, 0, 1, 4'h0, 32'hB00, 0, 1, 0, 0);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'hB0B0;
      step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hB0B0);

`ifdef MEM_ARB_STARVE_GUARD_EN
      // Four lost conflicts, accelerator forced through on the fifth
      cpu(1, 4'h0, 32'hC00, 0); acc(1, 0, 4'h0, 32'hC80, 0); mem_read_data = 0;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 32'hC00, 0, 0, 0, 0);
      step(1, 1, 1, 4'h0, 32'hC80, 0, 0, 0, 0);
      cpu(0, 4'h0, 0, 0); acc(0, 0, 4'h0, 0, 0); mem_read_data = 32'hC8C8;
      step(0, 0, 0, 4'h0, 0, 0, 1, 0, 0);

      // Counter restarted; forced locked grant stalls CPU, load data held
      cpu(1, 4'h0, 32'hD00, 0); acc(1, 1, 4'h0, 32'hD80, 0); mem_read_data = 0;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 32'hD00, 0, 0, 0, 0);
      mem_read_data = 32'h12345678;
      step(1, 1, 1, 4'h0, 32'hD80, 0, 0, 1, 32'h12345678);
      acc(1, 1, 4'h0, 32'hD84, 0); mem_read_data = 0;
      step(1, 1, 1, 4'h0, 32'hD84, 0, 1, 1, 32'h12345678);
      acc(0, 0, 4'h0, 0, 0); mem_read_data = 0;
      step(0, 0, 1, 4'h0, 32'hD00, 0, 1, 1, 32'h12345678);
      cpu(0, 4'h0, 0, 0); mem_read_data = 32'h7777;
      step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h7777);
`endif

      step(0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("acc_resp_drained", acc_q.size(), 0);
      chk("exp_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
